lif_neuron: RTL

Leaky integrate-and-fire neuron stage that sits directly downstream of the synaptic accumulator in the neuromorphic interface. On each `time_step` pulse it samples the accumulator's summed synaptic current. It then applies leak to the membrane potential, integrates the current, and compares the result to a programmable threshold. A crossing emits a one-cycle spike, resets the potential and enters a refractory period counted in time steps.

---
 rtl/lif_neuron.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// Leaky integrate-and-fire neuron stage. Every time_step pulse samples the
// summed synaptic current from the accumulator. The neuron then leaks the
// membrane potential, integrates the current with saturation, and compares the
// result against a programmable threshold. A crossing emits a one-cycle spike,
// reloads V_RESET and (optionally) starts a refractory period counted in steps.
//
// Optional feature macro: LIF_REFRACTORY_EN
//   defined   : refractory counter present; steps arriving while it is non-zero
//               are discarded and only decrement the counter.
//   undefined : no counter, refractory tied low, REFRACT_STEPS ignored.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   time_step   one-cycle pulse marking a new time step
//   acc_in      signed synaptic current, valid with time_step
//   thresh_we   threshold register write enable
//   thresh_in   new signed threshold value
//   spike       one-cycle spike pulse
//   v_mem       registered membrane potential
//   busy        high while an update is in progress
//   refractory  high while the refractory counter is non-zero
//   overrun     sticky: time_step seen while busy
// -----------------------------------------------------------------------------
module lif_neuron #(
   parameter int                       WIDTH         = 32,
   parameter logic signed [WIDTH-1:0]  THRESH_INIT   = 16,
   parameter int                       LEAK_SHIFT    = 3,
   parameter logic signed [WIDTH-1:0]  V_RESET       = 0,
   parameter int                       REFRACT_STEPS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     time_step,
   input  logic signed [WIDTH-1:0]  acc_in,
   input  logic                     thresh_we,
   input  logic signed [WIDTH-1:0]  thresh_in,
   output logic                     spike,
   output logic signed [WIDTH-1:0]  v_mem,
   output logic                     busy,
   output logic                     refractory,
   output logic                     overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAK  = 2'd1,
      INTEG = 2'd2,
      FIRE  = 2'd3
   } state_t;

   localparam logic signed [WIDTH-1:0] V_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] V_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                    state_reg, state_next;
   logic signed [WIDTH-1:0]   v_reg, v_next;
   logic signed [WIDTH-1:0]   acc_reg, acc_next;
   logic signed [WIDTH-1:0]   thresh_reg, thresh_next;
   logic                      spike_reg, spike_next;
   logic                      busy_reg, busy_next;
   logic                      overrun_reg, overrun_next;

   logic signed [WIDTH:0]     sum_ext;
   logic signed [WIDTH-1:0]   sum_sat;

`ifdef LIF_REFRACTORY_EN
   localparam logic [3:0] REFRACT_LOAD = 4'(REFRACT_STEPS);
   logic [3:0] refr_reg, refr_next;
`endif

   // One extra bit of headroom; the top two bits disagree exactly on overflow.
   always_comb begin
      sum_ext = {v_reg[WIDTH-1], v_reg} + {acc_reg[WIDTH-1], acc_reg};
      if (sum_ext[WIDTH] != sum_ext[WIDTH-1])
         sum_sat = sum_ext[WIDTH] ? V_MIN : V_MAX;
      else
         sum_sat = sum_ext[WIDTH-1:0];
   end

   always_comb begin
      state_next   = state_reg;
      v_next       = v_reg;
      acc_next     = acc_reg;
      thresh_next  = thresh_we ? thresh_in : thresh_reg;
      spike_next   = 1'b0;
      busy_next    = busy_reg;
      // A step landing on any busy cycle (including FIRE) is dropped.
      overrun_next = overrun_reg | (time_step & busy_reg);
`ifdef LIF_REFRACTORY_EN
      refr_next    = refr_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (time_step) begin
`ifdef LIF_REFRACTORY_EN
               if (refr_reg != 4'd0) begin
                  refr_next = refr_reg - 4'd1;
               end else begin
                  acc_next   = acc_in;
                  state_next = LEAK;
                  busy_next  = 1'b1;
               end
`else
               acc_next   = acc_in;
               state_next = LEAK;
               busy_next  = 1'b1;
`endif
            end
         end
         LEAK: begin
            // Arithmetic shift: negative potentials decay toward zero as well.
            v_next     = v_reg - (v_reg >>> LEAK_SHIFT);
            state_next = INTEG;
         end
         INTEG: begin
            v_next     = sum_sat;
            state_next = FIRE;
         end
         FIRE: begin
            // thresh_reg is the pre-write value even if thresh_we is high now.
            if (v_reg >= thresh_reg) begin
               spike_next = 1'b1;
               v_next     = V_RESET;
`ifdef LIF_REFRACTORY_EN
               refr_next  = REFRACT_LOAD;
`endif
            end
            state_next = IDLE;
            busy_next  = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         v_reg       <= V_RESET;
         acc_reg     <= '0;
         thresh_reg  <= THRESH_INIT;
         spike_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         v_reg       <= v_next;
         acc_reg     <= acc_next;
         thresh_reg  <= thresh_next;
         spike_reg   <= spike_next;
         busy_reg    <= busy_next;
         overrun_reg <= overrun_next;
      end
   end

`ifdef LIF_REFRACTORY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         refr_reg <= 4'd0;
      else
         refr_reg <= refr_next;
   end
   assign refractory = (refr_reg != 4'd0);
`else
   assign refractory = 1'b0;
`endif

   assign spike   = spike_reg;
   assign v_mem   = v_reg;
   assign busy    = busy_reg;
   assign overrun = overrun_reg;

endmodule
